// File: rtl/fetch_unit.sv
// RV32IC fetch stage: one-outstanding word fetch, halfword realignment buffer,
// and the registered pc/instruction pair handed to the decoder.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        id_compressed
);

  localparam logic [31:0] RESET_FA  = {RESET_PC[31:2], 2'b00};
  localparam logic [31:0] RESET_BPC = {RESET_PC[31:1], 1'b0};

  logic [15:0] hbuf [4];
  logic [15:0] nbuf [4];
  logic [2:0]  cnt;
  logic [31:0] fa;
  logic [31:0] bpc;
  logic        drop_low;
  logic        outstanding;
  logic        discard;

  logic        is32;
  logic        avail;
  logic        take;
  logic        accept_rsp;
  logic        issue;
  logic [2:0]  consumed;
  logic [2:0]  appended;
  logic [2:0]  base;
  logic [1:0]  widx;
  logic [1:0]  widx1;
  logic [2:0]  nxt_cnt;

  always_comb begin
    is32       = (hbuf[0][1:0] == 2'b11);
    avail      = is32 ? (cnt >= 3'd2) : (cnt >= 3'd1);
    take       = (!id_valid || !stall) && avail;
    consumed   = take ? (is32 ? 3'd2 : 3'd1) : 3'd0;
    accept_rsp = imem_rvalid && outstanding && !discard;
    appended   = accept_rsp ? (drop_low ? 3'd1 : 3'd2) : 3'd0;
    issue      = !outstanding && (cnt <= 3'd2) && !redirect;
    base       = cnt - consumed;
    widx       = base[1:0];
    widx1      = widx + 2'd1;
    nxt_cnt    = cnt - consumed + appended;

    for (int i = 0; i < 4; i++) nbuf[i] = hbuf[i];
    case (consumed)
      3'd1: begin
        nbuf[0] = hbuf[1];
        nbuf[1] = hbuf[2];
        nbuf[2] = hbuf[3];
      end
      3'd2: begin
        nbuf[0] = hbuf[2];
        nbuf[1] = hbuf[3];
      end
      default: ;
    endcase
    // Response halfwords land right behind whatever survives the consume.
    if (accept_rsp) begin
      if (drop_low) begin
        nbuf[widx] = imem_rdata[31:16];
      end else begin
        nbuf[widx]  = imem_rdata[15:0];
        nbuf[widx1] = imem_rdata[31:16];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid      <= 1'b0;
      id_pc         <= '0;
      id_instr      <= '0;
      id_compressed <= 1'b0;
      imem_req      <= 1'b0;
      imem_addr     <= '0;
      fa            <= RESET_FA;
      drop_low      <= RESET_PC[1];
      cnt           <= '0;
      bpc           <= RESET_BPC;
      // A fetch still in flight keeps the port busy until its data shows up and is thrown away.
      outstanding   <= outstanding && !imem_rvalid;
      discard       <= outstanding && !imem_rvalid;
    end else begin
      imem_req <= 1'b0;
      if (redirect) begin
        id_valid <= 1'b0;
        cnt      <= '0;
        bpc      <= {redirect_pc[31:1], 1'b0};
        fa       <= {redirect_pc[31:2], 2'b00};
        drop_low <= redirect_pc[1];
        if (outstanding) begin
          if (imem_rvalid) begin
            outstanding <= 1'b0;
            discard     <= 1'b0;
          end else begin
            discard <= 1'b1;
          end
        end
      end else begin
        hbuf <= nbuf;
        cnt  <= nxt_cnt;
        if (take) begin
          id_valid      <= 1'b1;
          id_pc         <= bpc;
          id_instr      <= is32 ? {hbuf[1], hbuf[0]} : {16'h0000, hbuf[0]};
          id_compressed <= !is32;
          bpc           <= bpc + (is32 ? 32'd4 : 32'd2);
        end else if (!stall) begin
          id_valid <= 1'b0;
        end
        if (imem_rvalid && outstanding) begin
          outstanding <= 1'b0;
          discard     <= 1'b0;
          if (accept_rsp && drop_low) drop_low <= 1'b0;
        end
        if (issue) begin
          imem_req    <= 1'b1;
          imem_addr   <= fa;
          fa          <= fa + 32'd4;
          outstanding <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Random fetch/stall/redirect/reset traffic against a static program image;
// the expected instruction stream is walked directly from that image.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_compressed;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .id_valid      (id_valid),
    .id_pc         (id_pc),
    .id_instr      (id_instr),
    .id_compressed (id_compressed)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [64];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] hw_at(input logic [31:0] pc);
    logic [31:0] w;
    w = mem[pc[7:2]];
    return pc[1] ? w[31:16] : w[15:0];
  endfunction

  logic [31:0] exp_pc, exp_fa, exp_instr, pend, h_next;
  logic [15:0] h0;
  logic        exp_c, busy, busy_before, chk_rst, chk_redir;
  int          lat, stall_burst, accepts;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h0093_4501;
    mem[1] = 32'h1234_0050;
    mem[2] = 32'h0050_0093;
    mem[3] = 32'h00A0_0113;
    mem[4] = 32'h0013_0001;
    mem[5] = {mem[5][31:16], 16'h0000};

    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    busy = 1'b0; lat = 0; pend = '0; stall_burst = 0; accepts = 0;
    exp_pc = {RESET_PC[31:1], 1'b0};
    exp_fa = {RESET_PC[31:2], 2'b00};
    chk_redir = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk_rst = 1'b1;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (chk_rst) begin
        check_val("rst_valid", {31'b0, id_valid}, 32'd0);
        check_val("rst_pc", id_pc, 32'd0);
        check_val("rst_instr", id_instr, 32'd0);
        check_val("rst_comp", {31'b0, id_compressed}, 32'd0);
        check_val("rst_req", {31'b0, imem_req}, 32'd0);
      end
      if (chk_redir) check_val("redir_valid", {31'b0, id_valid}, 32'd0);

      h0 = hw_at(exp_pc);
      if (h0[1:0] != 2'b11) begin
        exp_instr = {16'h0000, h0};
        exp_c     = 1'b1;
      end else begin
        h_next    = exp_pc + 32'd2;
        exp_instr = {hw_at(h_next), h0};
        exp_c     = 1'b0;
      end
      if (id_valid && !chk_rst && !chk_redir) begin
        check_val("id_pc", id_pc, exp_pc);
        check_val("id_instr", id_instr, exp_instr);
        check_val("id_comp", {31'b0, id_compressed}, {31'b0, exp_c});
      end

      busy_before = busy;
      imem_rvalid = 1'b0;
      if (busy) begin
        lat--;
        if (lat == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = pend;
          busy        = 1'b0;
        end
      end
      if (imem_req) begin
        check_val("one_outstanding", {31'b0, busy_before}, 32'd0);
        check_val("imem_addr", imem_addr, exp_fa);
        exp_fa = exp_fa + 32'd4;
        busy   = 1'b1;
        lat    = $urandom_range(1, 3);
        pend   = mem[imem_addr[7:2]];
      end

      rst      = ($urandom % 200) == 0;
      redirect = !rst && (($urandom % 25) == 0);
      case ($urandom % 4)
        0: redirect_pc = 32'h0000_0102;
        1: redirect_pc = 32'hFFFF_FFFC;
        2: redirect_pc = 32'hFFFF_FFFE;
        default: redirect_pc = $urandom;
      endcase
      if (stall_burst > 0) begin
        stall = 1'b1;
        stall_burst--;
      end else begin
        stall = ($urandom % 5) == 0;
        if (($urandom % 40) == 0) stall_burst = 5;
      end

      chk_rst   = 1'b0;
      chk_redir = 1'b0;
      if (rst) begin
        exp_pc  = {RESET_PC[31:1], 1'b0};
        exp_fa  = {RESET_PC[31:2], 2'b00};
        chk_rst = 1'b1;
      end else if (redirect) begin
        exp_pc    = {redirect_pc[31:1], 1'b0};
        exp_fa    = {redirect_pc[31:2], 2'b00};
        chk_redir = 1'b1;
      end else if (id_valid && !stall) begin
        exp_pc = exp_pc + (exp_c ? 32'd2 : 32'd4);
        accepts++;
      end

      @(posedge clk); #1;
    end

    check_val("progress", {31'b0, accepts >= 300}, 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
